five_to_twenty: RTL and testbench

- Gearbox that collects 5-word chunks into one 20-word bundle: four chunks make one bundle, or fewer when a chunk is flagged last.
- The first chunk received goes to the least significant end of the bundle, matching the LSB-first order of the 20-to-5 splitter.
- Sits upstream of the 20-to-5 splitter, or at the receive side of a 5-word lane, with valid/ready handshakes on both sides.
- An output holding register lets the next bundle start filling while the current bundle is stalled.

---
 rtl/five_to_twenty_pkg.sv | 12 +
 rtl/five_to_twenty_if.sv | 30 +++
 rtl/five_to_twenty.sv | 90 +++++++++
 tb/tb_five_to_twenty.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/five_to_twenty_pkg.sv
// Shared gearbox constants for the 5-to-20 collector and the 20-to-5 splitter.
package five_to_twenty_pkg;

  localparam int DEFAULT_WORD_LEN  = 66;
  localparam int CHUNK_WORDS       = 5;
  localparam int CHUNKS_PER_BUNDLE = 4;
  localparam int CNT_W             = 3;

  localparam int CHUNK_W  = CHUNK_WORDS * DEFAULT_WORD_LEN;
  localparam int BUNDLE_W = CHUNKS_PER_BUNDLE * CHUNK_W;

endpackage

// File: rtl/five_to_twenty_if.sv
// Chunk-in / bundle-out handshake bundle; slave is the gearbox, master the surrounding logic.
interface five_to_twenty_if
  import five_to_twenty_pkg::*;
#(
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) ();

  localparam int CW = CHUNK_WORDS * WORD_LEN;
  localparam int BW = CHUNKS_PER_BUNDLE * CW;

  logic [CW-1:0]    din;
  logic             din_valid;
  logic             din_last;
  logic             din_ready;
  logic [BW-1:0]    dout;
  logic [CNT_W-1:0] dout_chunks;
  logic             dout_valid;
  logic             dout_ready;

  modport slave (
    input  din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_chunks, dout_valid
  );

  modport master (
    output din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_chunks, dout_valid
  );

endinterface

// File: rtl/five_to_twenty.sv
// Collects 5-word chunks LSB-first into a 20-word bundle; a holding register
// lets the next bundle fill while the current one waits for downstream.
module five_to_twenty
  import five_to_twenty_pkg::*;
#(
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
  input  logic               clk,
  input  logic               arst,
  five_to_twenty_if.slave    bus
);

  localparam int CW = CHUNK_WORDS * WORD_LEN;
  localparam int BW = CHUNKS_PER_BUNDLE * CW;

  logic [3*CW-1:0]  acc_q, acc_d;
  logic [1:0]       fill_q, fill_d;
  logic [BW-1:0]    out_reg_q, out_reg_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_full_q, out_full_d;
  logic             din_ready;
  logic             acc_fire;
  logic             comp;

  // A completing chunk needs the holding register free (or freeing this cycle).
  assign din_ready = ((fill_q != 2'd3) && !bus.din_last) || !out_full_q || bus.dout_ready;
  assign acc_fire  = bus.din_valid && din_ready;
  assign comp      = acc_fire && ((fill_q == 2'd3) || bus.din_last);

  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    out_reg_d  = out_reg_q;
    out_cnt_d  = out_cnt_q;
    out_full_d = out_full_q;

    if (comp) begin
      // Unused upper slots are zeroed so no stale chunk leaks into a short bundle.
      out_reg_d = '0;
      for (int k = 0; k < 3; k++) begin
        if (k < int'(fill_q)) begin
          out_reg_d[k*CW +: CW] = acc_q[k*CW +: CW];
        end
      end
      for (int k = 0; k < CHUNKS_PER_BUNDLE; k++) begin
        if (k == int'(fill_q)) begin
          out_reg_d[k*CW +: CW] = bus.din;
        end
      end
      out_cnt_d  = CNT_W'({1'b0, fill_q}) + CNT_W'(1);
      out_full_d = 1'b1;
      acc_d      = '0;
      fill_d     = 2'd0;
    end else begin
      if (acc_fire) begin
        for (int k = 0; k < 3; k++) begin
          if (k == int'(fill_q)) begin
            acc_d[k*CW +: CW] = bus.din;
          end
        end
        fill_d = fill_q + 2'd1;
      end
      if (out_full_q && bus.dout_ready) begin
        out_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_q      <= '0;
      fill_q     <= 2'd0;
      out_reg_q  <= '0;
      out_cnt_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      out_reg_q  <= out_reg_d;
      out_cnt_q  <= out_cnt_d;
      out_full_q <= out_full_d;
    end
  end

  assign bus.din_ready   = din_ready;
  assign bus.dout        = out_reg_q;
  assign bus.dout_chunks = out_cnt_q;
  assign bus.dout_valid  = out_full_q;

endmodule

// File: tb/tb_five_to_twenty.sv
// Directed and random-loopback bench for the 5-to-20 gearbox with a queue-based bundle model.
module tb_five_to_twenty;
  import five_to_twenty_pkg::*;

  localparam int WL = 66;
  localparam int CW = 5 * WL;
  localparam int BW = 4 * CW;

  typedef logic [CW-1:0] chunk_t;
  typedef logic [BW-1:0] bundle_t;
  typedef struct {
    bundle_t data;
    int      cnt;
  } exp_t;

  logic   clk  = 1'b0;
  logic   arst = 1'b1;
  int     tests = 0;
  int     fails = 0;
  bit     rand_rdy = 1'b0;

  chunk_t pend[$];     // chunks accepted for the bundle being assembled
  exp_t   exp_q[$];    // bundles that must be presented, oldest first
  chunk_t loop_q[$];   // every accepted chunk, for the splitter-side check
  chunk_t ch[0:39];

  five_to_twenty_if #(.WORD_LEN(WL)) bus ();

  five_to_twenty #(.WORD_LEN(WL)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, bundle_t act, bundle_t exp);
    int w;
    tests++;
    if (act !== exp) begin
      w = 0;
      fails++;
      for (int i = 19; i >= 0; i--) begin
        if (act[i*WL +: WL] !== exp[i*WL +: WL]) w = i;
      end
      $display("FAIL %s: got word[%0d]=%h required %h", name, w, act[w*WL +: WL], exp[w*WL +: WL]);
    end
  endtask

  function automatic chunk_t mk_chunk(int k);
    chunk_t c;
    for (int w = 0; w < 5; w++) c[w*WL +: WL] = WL'(k * 'h1110 + w);
    return c;
  endfunction

  // A chunk is taken unless it would close a bundle while the output slot stays occupied.
  function automatic bit model_ready();
    bit closes;
    closes = (pend.size() == 3) || bus.din_last;
    return !closes || (exp_q.size() == 0) || bus.dout_ready;
  endfunction

  // Behavioural model: group accepted chunks into bundles, oldest chunk lowest.
  bit   m_acc, m_drain;
  exp_t m_e;
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      pend.delete();
      exp_q.delete();
      loop_q.delete();
    end else begin
      m_acc   = bus.din_valid && model_ready();
      m_drain = (exp_q.size() > 0) && bus.dout_ready;
      if (m_drain) void'(exp_q.pop_front());
      if (m_acc) begin
        pend.push_back(bus.din);
        loop_q.push_back(bus.din);
        if (pend.size() == 4 || bus.din_last) begin
          m_e.data = '0;
          for (int k = 0; k < pend.size(); k++) m_e.data[k*CW +: CW] = pend[k];
          m_e.cnt = pend.size();
          exp_q.push_back(m_e);
          pend.delete();
        end
      end
    end
  end

  // Splitter side: unpack each consumed bundle and match against the input order.
  always @(posedge clk) begin
    if (!arst && bus.dout_valid && bus.dout_ready) begin
      for (int k = 0; k < int'(bus.dout_chunks) && k < 4; k++) begin
        if (loop_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL loop_extra: got chunk %0d with no input pending, required none", k);
        end else begin
          chk("loop_chunk", BW'(bus.dout[k*CW +: CW]), BW'(loop_q.pop_front()));
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!arst) begin
      chk("valid", BW'(bus.dout_valid), BW'(exp_q.size() > 0));
      chk("din_ready", BW'(bus.din_ready), BW'(model_ready()));
      if (bus.dout_valid && exp_q.size() > 0) begin
        chk("dout", bus.dout, exp_q[0].data);
        chk("chunks", BW'(bus.dout_chunks), BW'(exp_q[0].cnt));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(chunk_t c, bit last);
    int n;
    n = 0;
    bus.din       = c;
    bus.din_last  = last;
    bus.din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.din_ready) begin
        sync();
        break;
      end
      sync();
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no din_ready in %0d cycles, required acceptance", n);
        break;
      end
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  initial begin
    chunk_t c;
    bit     last;
    for (int i = 0; i < 40; i++) ch[i] = mk_chunk(i + 1);
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.dout_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", bus.dout, '0);
    chk("rst_chunks", BW'(bus.dout_chunks), '0);
    chk("rst_valid", BW'(bus.dout_valid), '0);
    chk("rst_din_ready", BW'(bus.din_ready), BW'(1));
    @(posedge clk);
    #1 arst = 1'b0;

    // 1: back-to-back full bundle
    for (int i = 0; i < 4; i++) send(ch[i], 1'b0);
    @(negedge clk);
    chk("t1_dout", bus.dout, {ch[3], ch[2], ch[1], ch[0]});
    chk("t1_chunks", BW'(bus.dout_chunks), BW'(4));
    chk("t1_valid", BW'(bus.dout_valid), BW'(1));
    @(negedge clk);
    chk("t1_valid_drop", BW'(bus.dout_valid), '0);
    sync();

    // 2: partial flush then a clean full bundle
    send(ch[4], 1'b0);
    send(ch[5], 1'b1);
    @(negedge clk);
    chk("t2_dout", bus.dout, {{(2*CW){1'b0}}, ch[5], ch[4]});
    chk("t2_chunks", BW'(bus.dout_chunks), BW'(2));
    sync();
    for (int i = 6; i < 10; i++) send(ch[i], 1'b0);
    @(negedge clk);
    chk("t2_follow", bus.dout, {ch[9], ch[8], ch[7], ch[6]});
    sync();

    // 3: backpressure
    bus.dout_ready = 1'b0;
    for (int i = 10; i < 17; i++) send(ch[i], 1'b0);
    bus.din       = ch[17];
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk("t3_stall_ready", BW'(bus.din_ready), '0);
    chk("t3_hold", bus.dout, {ch[13], ch[12], ch[11], ch[10]});
    sync();
    @(negedge clk);
    chk("t3_stall_ready2", BW'(bus.din_ready), '0);
    sync();
    bus.dout_ready = 1'b1;
    #1 chk("t3_release_ready", BW'(bus.din_ready), BW'(1));
    sync();
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    @(negedge clk);
    chk("t3_second", bus.dout, {ch[17], ch[16], ch[15], ch[14]});
    chk("t3_second_valid", BW'(bus.dout_valid), BW'(1));
    sync();
    bus.dout_ready = 1'b1;
    sync();

    // 4: single-chunk last, then last on the fourth chunk
    send(ch[18], 1'b1);
    @(negedge clk);
    chk("t4_single", bus.dout, {{(3*CW){1'b0}}, ch[18]});
    chk("t4_single_cnt", BW'(bus.dout_chunks), BW'(1));
    sync();
    for (int i = 19; i < 22; i++) send(ch[i], 1'b0);
    send(ch[22], 1'b1);
    @(negedge clk);
    chk("t4_last4", bus.dout, {ch[22], ch[21], ch[20], ch[19]});
    chk("t4_last4_cnt", BW'(bus.dout_chunks), BW'(4));
    sync();

    // 5: reset with a held bundle and a partial bundle in flight
    bus.dout_ready = 1'b0;
    for (int i = 23; i < 29; i++) send(ch[i], 1'b0);
    #2 arst = 1'b1;
    #1;
    chk("t5_valid", BW'(bus.dout_valid), '0);
    chk("t5_din_ready", BW'(bus.din_ready), BW'(1));
    chk("t5_dout", bus.dout, '0);
    chk("t5_chunks", BW'(bus.dout_chunks), '0);
    #1 arst = 1'b0;
    bus.dout_ready = 1'b1;
    sync();
    for (int i = 29; i < 33; i++) send(ch[i], 1'b0);
    @(negedge clk);
    chk("t5_clean", bus.dout, {ch[32], ch[31], ch[30], ch[29]});
    chk("t5_clean_cnt", BW'(bus.dout_chunks), BW'(4));
    sync();

    // 6: random loopback
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) sync();
      for (int b = 0; b < CW; b++) c[b] = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 6) == 0) || (i == 999);
      send(c, last);
    end
    rand_rdy = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (4) sync();
    @(negedge clk);
    chk("t6_loop_residue", BW'(loop_q.size()), '0);
    chk("t6_final_valid", BW'(bus.dout_valid), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
